// File: rtl/rs_pkg.sv
// Shared types and default widths for the multi-CDB reservation station.
package rs_pkg;

    localparam int DEF_DEPTH   = 8;
    localparam int DEF_NUM_CDB = 2;
    localparam int DEF_ROB_W   = 4;
    localparam int DEF_OP_W    = 4;
    localparam int DEF_TAG_W   = DEF_ROB_W + 1;

    // Source tag: ROB index plus one extra bit; all-ones means the value is present.
    typedef logic [DEF_TAG_W-1:0] tag_t;

    localparam tag_t NO_DEP = '1;

endpackage

// File: rtl/rs_age_select.sv
// Issue selection for the reservation station. Returns a one-hot grant among
// the ready entries. With RS_AGE_ORDER_EN defined the oldest ready entry (by
// dispatch order) wins via a DEPTH x DEPTH age matrix; otherwise the lowest
// ready index wins and no age state exists.
module rs_age_select #(
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [DEPTH-1:0] i_ready,
    input  logic             i_disp_vld,
    input  logic [DEPTH-1:0] i_disp_oh,
    input  logic             i_free_vld,
    input  logic [DEPTH-1:0] i_free_oh,
    output logic [DEPTH-1:0] o_gnt
);

    logic [DEPTH-1:0] w_cand;

`ifdef RS_AGE_ORDER_EN
    // r_age[i][j] set means entry i was dispatched before entry j.
    logic [DEPTH-1:0][DEPTH-1:0] r_age;
    logic [DEPTH-1:0][DEPTH-1:0] w_age_n;

    // Next age matrix: freed entries drop their relations, a new entry
    // becomes younger than every other entry.
    always_comb begin
        w_age_n = r_age;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i_free_vld && (i_free_oh[i] || i_free_oh[j]))
                    w_age_n[i][j] = 1'b0;
                if (i_disp_vld && i_disp_oh[j] && (i != j))
                    w_age_n[i][j] = 1'b1;
                if (i_disp_vld && i_disp_oh[i])
                    w_age_n[i][j] = 1'b0;
            end
        end
    end

    // Age matrix register, cleared by reset and flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_age <= '0;
        else if (i_flush)
            r_age <= '0;
        else
            r_age <= w_age_n;
    end

    // A ready entry is a candidate when no other ready entry is older.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic w_blk;
            w_blk = 1'b0;
            for (int j = 0; j < DEPTH; j++)
                if (i_ready[j] && r_age[j][i])
                    w_blk = 1'b1;
            w_cand[i] = i_ready[i] && !w_blk;
        end
    end
`else
    logic w_unused_age;
    assign w_unused_age = ^{i_clk, i_rst_n, i_flush, i_disp_vld, i_disp_oh,
                            i_free_vld, i_free_oh};
    assign w_cand = i_ready;
`endif

    // Lowest set candidate bit; also guarantees a strictly one-hot grant.
    assign o_gnt = w_cand & (~w_cand + DEPTH'(1));

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station with NUM_CDB result broadcast ports. Entries snoop all
// CDB ports at dispatch and while waiting; one ready entry per cycle moves
// into a registered issue slot held until the ALU accepts it.
// Optional macro RS_AGE_ORDER_EN: oldest-first issue instead of lowest index.
module rs_multi_cdb
    import rs_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int ROB_W   = DEF_ROB_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         disp_valid_in,
    input  logic [OP_W-1:0]              disp_op_l1_in,
    input  logic                         disp_op_l2_in,
    input  logic [ROB_W:0]               disp_q1_in,
    input  logic [ROB_W:0]               disp_q2_in,
    input  logic [31:0]                  disp_v1_in,
    input  logic [31:0]                  disp_v2_in,
    input  logic [ROB_W-1:0]             disp_rob_id_in,
    input  logic [NUM_CDB-1:0]           cdb_valid_in,
    input  logic [NUM_CDB*(ROB_W+1)-1:0] cdb_tag_in,
    input  logic [NUM_CDB*32-1:0]        cdb_value_in,
    output logic                         issue_valid_out,
    input  logic                         issue_ready_in,
    output logic [OP_W-1:0]              issue_op_l1_out,
    output logic                         issue_op_l2_out,
    output logic [31:0]                  issue_opr1_out,
    output logic [31:0]                  issue_opr2_out,
    output logic [ROB_W:0]               issue_tag_out,
    output logic                         full_out,
    output logic [$clog2(DEPTH):0]       count_out
);

    localparam int TW = ROB_W + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [TW-1:0] TAG_NONE = '1;

    // Entry storage
    logic [DEPTH-1:0]                r_busy;
    logic [DEPTH-1:0][OP_W-1:0]      r_op_l1;
    logic [DEPTH-1:0]                r_op_l2;
    logic [DEPTH-1:0][TW-1:0]        r_q1, r_q2;
    logic [DEPTH-1:0][31:0]          r_v1, r_v2;
    logic [DEPTH-1:0][ROB_W-1:0]     r_rob;
    logic [CW-1:0]                   r_count;

    // Issue slot
    logic                            r_iss_vld;
    logic [OP_W-1:0]                 r_iss_op_l1;
    logic                            r_iss_op_l2;
    logic [31:0]                     r_iss_opr1, r_iss_opr2;
    logic [ROB_W-1:0]                r_iss_rob;

    logic [DEPTH-1:0][TW-1:0]        w_q1_n, w_q2_n;
    logic [DEPTH-1:0][31:0]          w_v1_n, w_v2_n;
    logic [TW-1:0]                   w_dq1, w_dq2;
    logic [31:0]                     w_dv1, w_dv2;
    logic [DEPTH-1:0]                w_free_oh;
    logic [DEPTH-1:0]                w_ready;
    logic [DEPTH-1:0]                w_gnt;
    logic                            w_full;
    logic                            w_disp_fire;
    logic                            w_load;
    logic [OP_W-1:0]                 w_sel_op_l1;
    logic                            w_sel_op_l2;
    logic [31:0]                     w_sel_v1, w_sel_v2;
    logic [ROB_W-1:0]                w_sel_rob;

    // Resolve one operand against the CDB; the lowest matching port wins.
    function automatic logic [TW+31:0] f_snoop(
        input logic [TW-1:0]          q,
        input logic [31:0]            v,
        input logic [NUM_CDB-1:0]     vld,
        input logic [NUM_CDB*TW-1:0]  tags,
        input logic [NUM_CDB*32-1:0]  vals
    );
        logic [TW-1:0] rq;
        logic [31:0]   rv;
        rq = q;
        rv = v;
        if (q != TAG_NONE) begin
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (vld[p] && (tags[p*TW +: TW] == q)) begin
                    rq = TAG_NONE;
                    rv = vals[p*32 +: 32];
                end
            end
        end
        return {rq, rv};
    endfunction

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_disp_fire = rdy_in && !flush_in && disp_valid_in && !w_full;

    // Dispatch-time operand capture from a same-cycle broadcast.
    always_comb begin
        {w_dq1, w_dv1} = f_snoop(disp_q1_in, disp_v1_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
        {w_dq2, w_dv2} = f_snoop(disp_q2_in, disp_v2_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
    end

    // Wakeup of waiting entries from any CDB port.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            {w_q1_n[e], w_v1_n[e]} = f_snoop(r_q1[e], r_v1[e], cdb_valid_in, cdb_tag_in, cdb_value_in);
            {w_q2_n[e], w_v2_n[e]} = f_snoop(r_q2[e], r_v2[e], cdb_valid_in, cdb_tag_in, cdb_value_in);
        end
    end

    // Lowest-index free entry as a one-hot.
    always_comb begin
        logic w_found;
        w_found   = 1'b0;
        w_free_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_busy[i] && !w_found) begin
                w_free_oh[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    // Readiness comes from registered state only, so wakeups are seen next cycle.
    always_comb begin
        for (int e = 0; e < DEPTH; e++)
            w_ready[e] = r_busy[e] && (r_q1[e] == TAG_NONE) && (r_q2[e] == TAG_NONE);
    end

    rs_age_select #(.DEPTH(DEPTH)) u_sel (
        .i_clk      (clk_in),
        .i_rst_n    (rst_n_in),
        .i_flush    (flush_in),
        .i_ready    (w_ready),
        .i_disp_vld (w_disp_fire),
        .i_disp_oh  (w_free_oh),
        .i_free_vld (w_load),
        .i_free_oh  (w_gnt),
        .o_gnt      (w_gnt)
    );

    assign w_load = rdy_in && !flush_in && (|w_ready) && (!r_iss_vld || issue_ready_in);

    // Payload mux for the granted entry.
    always_comb begin
        w_sel_op_l1 = '0;
        w_sel_op_l2 = 1'b0;
        w_sel_v1    = '0;
        w_sel_v2    = '0;
        w_sel_rob   = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_gnt[e]) begin
                w_sel_op_l1 = r_op_l1[e];
                w_sel_op_l2 = r_op_l2[e];
                w_sel_v1    = r_v1[e];
                w_sel_v2    = r_v2[e];
                w_sel_rob   = r_rob[e];
            end
        end
    end

    // Entry state: wakeup, dispatch write, busy clear on issue load.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy  <= '0;
            r_op_l1 <= '0;
            r_op_l2 <= '0;
            r_q1    <= '1;
            r_q2    <= '1;
            r_v1    <= '0;
            r_v2    <= '0;
            r_rob   <= '0;
        end else if (flush_in) begin
            r_busy <= '0;
        end else if (rdy_in) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_q1[e] <= w_q1_n[e];
                r_q2[e] <= w_q2_n[e];
                r_v1[e] <= w_v1_n[e];
                r_v2[e] <= w_v2_n[e];
                if (w_load && w_gnt[e])
                    r_busy[e] <= 1'b0;
                if (w_disp_fire && w_free_oh[e]) begin
                    r_busy[e]  <= 1'b1;
                    r_op_l1[e] <= disp_op_l1_in;
                    r_op_l2[e] <= disp_op_l2_in;
                    r_q1[e]    <= w_dq1;
                    r_q2[e]    <= w_dq2;
                    r_v1[e]    <= w_dv1;
                    r_v2[e]    <= w_dv2;
                    r_rob[e]   <= disp_rob_id_in;
                end
            end
        end
    end

    // Occupancy: dispatch adds, issue load removes; both together cancel.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_count <= '0;
        else if (flush_in)
            r_count <= '0;
        else if (w_disp_fire && !w_load)
            r_count <= r_count + CW'(1);
        else if (!w_disp_fire && w_load)
            r_count <= r_count - CW'(1);
    end

    // Issue slot: loads on empty or accepted slot, otherwise holds.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_iss_vld   <= 1'b0;
            r_iss_op_l1 <= '0;
            r_iss_op_l2 <= 1'b0;
            r_iss_opr1  <= '0;
            r_iss_opr2  <= '0;
            r_iss_rob   <= '0;
        end else if (flush_in) begin
            r_iss_vld <= 1'b0;
        end else if (rdy_in) begin
            if (w_load) begin
                r_iss_vld   <= 1'b1;
                r_iss_op_l1 <= w_sel_op_l1;
                r_iss_op_l2 <= w_sel_op_l2;
                r_iss_opr1  <= w_sel_v1;
                r_iss_opr2  <= w_sel_v2;
                r_iss_rob   <= w_sel_rob;
            end else if (r_iss_vld && issue_ready_in) begin
                r_iss_vld <= 1'b0;
            end
        end
    end

    assign issue_valid_out = r_iss_vld;
    assign issue_op_l1_out = r_iss_op_l1;
    assign issue_op_l2_out = r_iss_op_l2;
    assign issue_opr1_out  = r_iss_opr1;
    assign issue_opr2_out  = r_iss_opr2;
    assign issue_tag_out   = {1'b0, r_iss_rob};
    assign full_out        = w_full;
    assign count_out       = r_count;

endmodule

// File: doc/rs_multi_cdb.md
RS_MULTI_CDB -- requirements
Module: rs_multi_cdb

Interface
REQ-001 Parameter DEPTH, default 8: number of station entries, power of two, minimum 2.
REQ-002 Parameter NUM_CDB, default 2: number of result broadcast (CDB) ports.
REQ-003 Parameter ROB_W, default 4: ROB index width; tags are ROB_W+1 bits, and all-ones means "no dependency".
REQ-004 Parameter OP_W, default 4: width of the L1 operation code; the L2 op bit is separate.
REQ-005 clk_in  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-007 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-008 flush_in  input  1  mispredict flush.
REQ-009 disp_valid_in  input  1  dispatch request.
REQ-010 disp_op_l1_in / disp_op_l2_in  input  OP_W / 1  operation code.
REQ-011 disp_q1_in, disp_q2_in  input  ROB_W+1 each  source tags, already resolved by decode/ROB lookup.
REQ-012 disp_v1_in, disp_v2_in  input  32 each  source values, valid when the matching tag is all-ones.
REQ-013 disp_rob_id_in  input  ROB_W  destination ROB index.
REQ-014 cdb_valid_in / cdb_tag_in / cdb_value_in  input  NUM_CDB / NUM_CDB*(ROB_W+1) / NUM_CDB*32  broadcast ports.
REQ-015 issue_valid_out  output  1  issue request to the ALU.
REQ-016 issue_ready_in  input  1  ALU accepts the issue.
REQ-017 issue_op_l1_out / issue_op_l2_out / issue_opr1_out / issue_opr2_out / issue_tag_out  output  OP_W / 1 / 32 / 32 / ROB_W+1  issued payload; tag = {1'b0, rob_id}.
REQ-018 full_out  output  1  high when count equals DEPTH.
REQ-019 count_out  output  log2(DEPTH)+1  occupied entries.

Function
REQ-020 Dispatch writes the lowest-index free entry when disp_valid_in is high and full_out is low; dispatch while full SHALL be dropped with no state change.
REQ-021 At dispatch, each operand whose tag matches a valid CDB port in the same cycle SHALL capture that value and store tag all-ones; on a multi-port match, the lowest port index wins.
REQ-022 Each cycle, every busy entry whose q1/q2 matches any valid CDB tag SHALL capture the value and clear the tag to all-ones.
REQ-023 Selection uses registered entry state only; an entry dispatched or woken in cycle N is first eligible in cycle N+1.
REQ-024 The output register loads the selected ready entry when issue_valid_out is low or the handshake completes; the entry's busy bit clears on load.
REQ-025 issue_valid_out and the payload SHALL hold stable until issue_ready_in is high.
REQ-026 Simultaneous dispatch and issue-load SHALL leave count unchanged; count never wraps.
REQ-027 flush_in SHALL clear all busy bits and issue_valid_out, and set count to 0; flush has priority over dispatch, wakeup and issue in the same cycle.
REQ-028 rdy_in low SHALL suppress dispatch, wakeup and issue, but not reset or flush-by-reset.

Reset
REQ-029 rst_n_in low asynchronously clears busy bits, the age state, count_out, full_out and issue_valid_out; sets tags to all-ones; and zeroes the payload outputs.

Configuration
REQ-030 With RS_AGE_ORDER_EN defined, selection SHALL pick the oldest ready entry by dispatch order, tracked by a DEPTH x DEPTH age matrix updated on dispatch and clear.
REQ-031 Without RS_AGE_ORDER_EN, selection SHALL pick the lowest-index ready entry, and no age storage is built.

Structure
REQ-032 Shared package rs_pkg SHALL hold the tag type, the NO_DEP all-ones constant, and the default widths.
REQ-033 Oldest/lowest selection SHALL live in one sub-module, rs_age_select: inputs are the ready vector and dispatch/free events; output is a one-hot grant.

Verification
REQ-034 Dispatch q1=FF, v1=5, q2=FF, v2=7, ALU ready -> issue_valid_out high two cycles later, with opr1=5, opr2=7, tag={0,rob_id}.
REQ-035 Dispatch q1=3 while CDB port 1 broadcasts tag 3 with value 0x42 the same cycle -> entry issues with opr1=0x42 and no further wait.
REQ-036 Fill all 8 entries, then dispatch a 9th -> full_out=1, count_out=8, and the 9th is dropped; after one issue handshake, count_out=7.
REQ-037 With RS_AGE_ORDER_EN, dispatch A into entry 5 then B into entry 2, and wake both in the same cycle -> A issues before B; without the macro, B issues first.
REQ-038 Hold issue_ready_in=0 for 4 cycles -> payload stable and count unchanged; then issue_ready_in=1 -> next ready entry loads the following cycle.
REQ-039 Assert flush_in with 5 entries busy and an issue pending, plus a simultaneous dispatch -> count_out=0, issue_valid_out=0 next cycle, and the dispatch is dropped.
